// File: rtl/fluxo_dados_n.sv
// fluxo_dados_n: game datapath with counters, play register, memory, play-edge detector and timeout (FLUXO_DADOS_N_TIMEOUT_EN adds the timeout counter)
module fluxo_dados_n #(
  parameter int WIDTH          = 4,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  zeraE,
  input  logic                  contaE,
  input  logic                  zeraS,
  input  logic                  contaS,
  input  logic                  zeraR,
  input  logic                  registraR,
  input  logic                  escreveM,
  input  logic                  zeraT,
  input  logic                  contaT,
  input  logic [WIDTH-1:0]      chaves,
  output logic                  jogada_igual_memoria,
  output logic                  endereco_igual_sequencia,
  output logic                  fimE,
  output logic                  fimS,
  output logic                  tem_jogada,
  output logic                  timeout,
  output logic [ADDR_WIDTH-1:0] db_endereco,
  output logic [ADDR_WIDTH-1:0] db_sequencia,
  output logic [WIDTH-1:0]      db_memoria,
  output logic [WIDTH-1:0]      db_jogada
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] endereco_q, endereco_d, sequencia_q, sequencia_d;
  logic [WIDTH-1:0]      jogada_q, jogada_d, memoria_q;
  logic [WIDTH-1:0]      words [DEPTH];
  logic                  hist_q, tem_q;
  // next state of counters and play register: clear beats count/load
  always_comb begin
    endereco_d  = zeraE ? '0 : contaE ? endereco_q + ADDR_WIDTH'(1) : endereco_q;
    sequencia_d = zeraS ? '0 : contaS ? sequencia_q + ADDR_WIDTH'(1) : sequencia_q;
    jogada_d    = zeraR ? '0 : registraR ? chaves : jogada_q;
  end
  // datapath state; the read register samples the pre-edge address so a same-edge write shows up one cycle later
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endereco_q  <= '0;
      sequencia_q <= '0;
      jogada_q    <= '0;
      memoria_q   <= '0;
      hist_q      <= 1'b0;
      tem_q       <= 1'b0;
    end else begin
      endereco_q  <= endereco_d;
      sequencia_q <= sequencia_d;
      jogada_q    <= jogada_d;
      memoria_q   <= words[endereco_q];
      hist_q      <= |chaves;
      tem_q       <= (|chaves) & ~hist_q;
    end
  end
  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    logic [WIDTH-1:0] word_q = WIDTH'(1) << (i % WIDTH);
    // memory word keeps its power-up pattern across reset; writes on a reset edge are dropped
    always_ff @(posedge clock)
      if (escreveM && !reset && endereco_q == ADDR_WIDTH'(i)) word_q <= jogada_q;
    assign words[i] = word_q;
  end
`ifdef FLUXO_DADOS_N_TIMEOUT_EN
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LIMITE = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tempo_q, tempo_d;
  // a new play or explicit clear restarts the timer; otherwise count and hold at the limit
  always_comb tempo_d = (zeraT || tem_q) ? '0 : (contaT && tempo_q != LIMITE) ? tempo_q + TW'(1) : tempo_q;
  // timeout counter register
  always_ff @(posedge clock or posedge reset)
    if (reset) tempo_q <= '0;
    else tempo_q <= tempo_d;
  assign timeout = tempo_q == LIMITE;
`else
  logic unused_tempo;
  assign unused_tempo = zeraT ^ contaT ^ (TIMEOUT_CYCLES == 0);
  assign timeout      = 1'b0;
`endif
  assign fimE                     = &endereco_q;
  assign fimS                     = &sequencia_q;
  assign endereco_igual_sequencia = endereco_q == sequencia_q;
  assign jogada_igual_memoria     = memoria_q == jogada_q;
  assign tem_jogada               = tem_q;
  assign db_endereco              = endereco_q;
  assign db_sequencia             = sequencia_q;
  assign db_memoria               = memoria_q;
  assign db_jogada                = jogada_q;
endmodule

// File: tb/tb_fluxo_dados_n.sv
// tb_fluxo_dados_n: scoreboard bench comparing fluxo_dados_n against a behavioural game model
module tb_fluxo_dados_n;
  localparam int TO = 8;
  logic clock = 1'b0, reset = 1'b1;
  logic zeraE = 0, contaE = 0, zeraS = 0, contaS = 0, zeraR = 0, registraR = 0;
  logic escreveM = 0, zeraT = 0, contaT = 0;
  logic [3:0] chaves = '0;
  logic jogada_igual_memoria, endereco_igual_sequencia, fimE, fimS, tem_jogada, timeout;
  logic [3:0] db_endereco, db_sequencia, db_memoria, db_jogada;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic ze, ce, zs, cs, zr, rr, wm, zt, ct;
    logic [3:0] ch;
  } in_t;
  typedef struct packed {
    logic [3:0] addr, seq, rd, play;
    logic fe, fs, eqs, jig, tem, tout;
  } exp_t;
  exp_t sb[$];
  int m_addr, m_seq, m_play, m_rd, m_tmr;
  bit m_prev, m_tem;
  logic [3:0] m_mem [16];
  fluxo_dados_n #(.WIDTH(4), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS), .contaS(contaS),
    .zeraR(zeraR), .registraR(registraR), .escreveM(escreveM), .zeraT(zeraT), .contaT(contaT),
    .chaves(chaves), .jogada_igual_memoria(jogada_igual_memoria),
    .endereco_igual_sequencia(endereco_igual_sequencia), .fimE(fimE), .fimS(fimS),
    .tem_jogada(tem_jogada), .timeout(timeout), .db_endereco(db_endereco),
    .db_sequencia(db_sequencia), .db_memoria(db_memoria), .db_jogada(db_jogada)
  );
  always #5 clock = ~clock;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_addr = 0; m_seq = 0; m_play = 0; m_rd = 0; m_tmr = 0; m_prev = 0; m_tem = 0;
  endtask
  task automatic model_edge(in_t s);
    int rd;
    exp_t e;
    rd = m_mem[m_addr];
    if (s.wm) m_mem[m_addr] = 4'(m_play);
    if (s.zt || m_tem) m_tmr = 0;
    else if (s.ct && m_tmr < TO - 1) m_tmr++;
    m_tem = (s.ch != 0) && !m_prev;
    m_prev = s.ch != 0;
    m_addr = s.ze ? 0 : s.ce ? (m_addr + 1) % 16 : m_addr;
    m_seq = s.zs ? 0 : s.cs ? (m_seq + 1) % 16 : m_seq;
    m_play = s.zr ? 0 : s.rr ? int'(s.ch) : m_play;
    m_rd = rd;
    e.addr = 4'(m_addr); e.seq = 4'(m_seq); e.rd = 4'(m_rd); e.play = 4'(m_play);
    e.fe = m_addr == 15; e.fs = m_seq == 15; e.eqs = m_addr == m_seq; e.jig = m_rd == m_play;
    e.tem = m_tem;
`ifdef FLUXO_DADOS_N_TIMEOUT_EN
    e.tout = m_tmr == TO - 1;
`else
    e.tout = 1'b0;
`endif
    sb.push_back(e);
  endtask
  task automatic step(in_t s);
    zeraE = s.ze; contaE = s.ce; zeraS = s.zs; contaS = s.cs; zeraR = s.zr; registraR = s.rr;
    escreveM = s.wm; zeraT = s.zt; contaT = s.ct; chaves = s.ch;
    model_edge(s);
    @(negedge clock);
  endtask
  task automatic reset_checks();
    chk("rst_endereco", 32'(db_endereco), 0);
    chk("rst_sequencia", 32'(db_sequencia), 0);
    chk("rst_jogada", 32'(db_jogada), 0);
    chk("rst_memoria", 32'(db_memoria), 0);
    chk("rst_fimE", 32'(fimE), 0);
    chk("rst_fimS", 32'(fimS), 0);
    chk("rst_end_eq_seq", 32'(endereco_igual_sequencia), 1);
    chk("rst_tem_jogada", 32'(tem_jogada), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_jog_eq_mem", 32'(jogada_igual_memoria), 1);
  endtask
  // monitor: every edge is an output event; compare DUT against the oldest prediction
  initial forever begin
    exp_t e;
    @(posedge clock);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("db_endereco", 32'(db_endereco), 32'(e.addr));
      chk("db_sequencia", 32'(db_sequencia), 32'(e.seq));
      chk("db_memoria", 32'(db_memoria), 32'(e.rd));
      chk("db_jogada", 32'(db_jogada), 32'(e.play));
      chk("fimE", 32'(fimE), 32'(e.fe));
      chk("fimS", 32'(fimS), 32'(e.fs));
      chk("end_eq_seq", 32'(endereco_igual_sequencia), 32'(e.eqs));
      chk("jog_eq_mem", 32'(jogada_igual_memoria), 32'(e.jig));
      chk("tem_jogada", 32'(tem_jogada), 32'(e.tem));
      chk("timeout", 32'(timeout), 32'(e.tout));
    end
  end
  initial begin
    in_t s;
    for (int i = 0; i < 16; i++) m_mem[i] = 4'(1 << (i % 4));
    model_reset();
    @(negedge clock);
    reset_checks();
    reset = 1'b0;
    s = '0; s.ce = 1;
    repeat (16) step(s);
    s = '0; s.ch = 4'b0100;
    repeat (3) step(s);
    s.ch = 4'b0000; step(s);
    s.ch = 4'b0001; repeat (2) step(s);
    s = '0; s.ze = 1; step(s);
    s = '0; s.ce = 1; repeat (2) step(s);
    s = '0; s.rr = 1; s.ch = 4'b0100; step(s);
    s = '0; repeat (2) step(s);
    s.rr = 1; s.ch = 4'b1000; step(s);
    s = '0; repeat (2) step(s);
    s.ce = 1; repeat (3) step(s);
    s = '0; s.rr = 1; s.ch = 4'b1010; step(s);
    s = '0; step(s);
    s.wm = 1; step(s);
    s = '0; repeat (2) step(s);
    s.zt = 1; step(s);
    s = '0; s.ct = 1; repeat (10) step(s);
    s.ch = 4'b0001; repeat (2) step(s);
    s.ch = 4'b0000; repeat (3) step(s);
    s = '0; s.ze = 1; s.zs = 1; step(s);
    s = '0; s.ce = 1; repeat (6) step(s);
    s = '0; s.cs = 1; repeat (3) step(s);
    s = '0; s.rr = 1; s.ch = 4'b1001; step(s);
    s = '0; s.ct = 1; repeat (2) step(s);
    s = '0; s.wm = 1;
    zeraE = 0; contaE = 0; zeraS = 0; contaS = 0; zeraR = 0; registraR = 0;
    escreveM = 1; zeraT = 0; contaT = 0; chaves = '0;
    #2 reset = 1'b1;
    #1 reset_checks();
    #1 reset = 1'b0;
    model_reset();
    s = '0; step(s);
    s.ce = 1; repeat (6) step(s);
    s = '0; repeat (2) step(s);
    repeat (600) begin
      s.ze = ($urandom % 16) == 0; s.ce = 1'($urandom); s.zs = ($urandom % 16) == 0;
      s.cs = 1'($urandom); s.zr = ($urandom % 8) == 0; s.rr = ($urandom % 3) == 0;
      s.wm = ($urandom % 4) == 0; s.zt = ($urandom % 20) == 0; s.ct = ($urandom % 4) != 0;
      s.ch = ($urandom % 2) ? 4'b0000 : 4'($urandom);
      step(s);
    end
    @(negedge clock);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fluxo_dados_n.md
FLUXO_DADOS_N -- requirements
Module: fluxo_dados_n

Interface
REQ-001 Parameter WIDTH, default 4: width of chaves, memory word, play register and comparators.
REQ-002 Parameter ADDR_WIDTH, default 4: width of address/sequence counters; memory depth is 2^ADDR_WIDTH.
REQ-003 Parameter TIMEOUT_CYCLES, default 5000: play-timeout limit in clock cycles.
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 zeraE, contaE  input  1 each  address counter synchronous clear / count enable.
REQ-007 zeraS, contaS  input  1 each  sequence counter synchronous clear / count enable.
REQ-008 zeraR, registraR  input  1 each  play register synchronous clear / load enable.
REQ-009 escreveM  input  1  write registered play into memory at current address.
REQ-010 zeraT, contaT  input  1 each  timeout counter synchronous clear / count enable.
REQ-011 chaves  input  WIDTH  player buttons.
REQ-012 jogada_igual_memoria, endereco_igual_sequencia, fimE, fimS, tem_jogada, timeout  output  1 each  status to control unit.
REQ-013 db_endereco, db_sequencia  output  ADDR_WIDTH; db_memoria, db_jogada  output  WIDTH  debug taps.

Function
REQ-014 Counter priority per edge: reset > zera* > conta*; conta* increments by 1, wraps from 2^ADDR_WIDTH-1 to 0.
REQ-015 fimE = (endereco == all ones), fimS = (sequencia == all ones), combinational from counter state.
REQ-016 endereco_igual_sequencia = (endereco == sequencia), combinational.
REQ-017 Play register: zeraR clears to 0; else registraR loads chaves; zeraR wins if both asserted.
REQ-018 Memory read is synchronous: db_memoria reflects the word at the address present on the previous edge (1-cycle latency).
REQ-019 escreveM writes db_jogada into memory[endereco] on the edge; the read on that same edge returns the old word, the new word appears one cycle later.
REQ-020 Power-up memory contents: word i = one-hot (1 << (i mod WIDTH)); reset does not alter memory.
REQ-021 jogada_igual_memoria = (db_memoria == db_jogada), combinational.
REQ-022 tem_jogada is a one-cycle pulse on the first edge where OR(chaves)=1 after an edge where OR(chaves)=0; held buttons produce no further pulse.
REQ-023 Timeout counter: cleared by zeraT or tem_jogada (clear wins over count); counts while contaT; saturates at TIMEOUT_CYCLES-1.
REQ-024 timeout = 1 while the timeout counter equals TIMEOUT_CYCLES-1; stays 1 until cleared.
REQ-025 Simultaneous escreveM and contaE: write uses the pre-increment address.

Reset
REQ-026 reset asynchronously forces endereco=0, sequencia=0, play register=0, timeout counter=0, edge-detector history=0, memory read register=0.
REQ-027 Consequently after reset: fimE=0, fimS=0, endereco_igual_sequencia=1, tem_jogada=0, timeout=0, jogada_igual_memoria=1.
REQ-028 Reset asserted mid-operation aborts any pending write; no memory word is modified on an edge where reset is high.

Configuration
REQ-029 Macro FLUXO_DADOS_N_TIMEOUT_EN: defined compiles in the timeout counter (REQ-023/024); undefined removes it, timeout tied to 0, zeraT/contaT ignored.

Verification
REQ-030 reset, then contaE for 15 cycles -> db_endereco=15, fimE=1; one more -> db_endereco=0, fimE=0.
REQ-031 After reset, chaves=4'b0100 held 3 cycles -> tem_jogada high exactly on edge 1; chaves=0 then 4'b0001 -> second single pulse.
REQ-032 endereco=2, registraR with chaves=4'b0100 -> next-cycle jogada_igual_memoria=1; with chaves=4'b1000 -> 0.
REQ-033 endereco=5, db_jogada=4'b1010, escreveM one cycle -> db_memoria=4'b0010 that cycle, 4'b1010 the cycle after.
REQ-034 TIMEOUT_CYCLES=8, macro defined, contaT held -> timeout rises after 7 edges and stays; tem_jogada pulse -> timeout=0 next cycle; macro undefined -> timeout always 0.
REQ-035 reset pulsed between edges during escreveM with all counters nonzero -> outputs per REQ-027 immediately, target memory word unchanged.
